fft_frame_unloader: RTL
=======================

Name: fft_frame_unloader

Overview:
- Output end of the FFT datapath: takes one 8-point frame in parallel from the final butterfly stage and streams it out one complex sample per cycle over a valid/ready handshake.
- Reorders the frame from bit-reversed to natural order when enabled.
- Holds up to two frames in ping-pong buffers, so the butterfly pipeline can hand over the next frame while the current one drains.

Parameters:
- DATA_W, 50: complex sample width, {re[DATA_W-1:DATA_W/2], im[DATA_W/2-1:0]}, passed through untouched.
- POINTS, 8: frame length. Must be a power of two and at least 2.
- BIT_REVERSE, 1: when 1, output sample k is frame[bitrev(k)]; when 0, output sample k is frame[k].

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- frame_i  in  DATA_W x POINTS (unpacked [POINTS-1:0])  parallel frame from the butterfly stage.
- frame_valid_i  in  1  frame_i is valid.
- frame_ready_o  out  1  unloader can accept a frame.
- sample_o  out  DATA_W  current output sample.
- sample_idx_o  out  log2(POINTS)  natural-order index k of sample_o.
- sample_valid_o  out  1  sample_o is valid.
- sample_last_o  out  1  sample_o is the last sample of the frame (k == POINTS-1).
- sample_ready_i  in  1  downstream accepts sample_o.

Behaviour:
- State:
  - buf[2][POINTS] data registers.
  - wr_ptr, rd_ptr: 1-bit each.
  - count: 0..2 frames held.
  - idx: log2(POINTS) bits.
- Reset (rst_i low, asynchronous):
  - count=0, wr_ptr=0, rd_ptr=0, idx=0, buffers cleared to 0.
  - Outputs: frame_ready_o=1, sample_valid_o=0, sample_o=0, sample_idx_o=0, sample_last_o=0.
  - Reset mid-frame drops all held frames. No partial output after release.
- Frame ready and accept:
  - frame_ready_o = (count < 2), derived from registered state only. It does not depend on sample_ready_i in the same cycle.
  - Accept occurs on frame_valid_i && frame_ready_o at a rising edge: buf[wr_ptr] <= frame_i, wr_ptr toggles.
- Output:
  - sample_valid_o = (count != 0).
  - sample_o = buf[rd_ptr][BIT_REVERSE ? bitrev(idx) : idx] when valid, otherwise 0.
  - sample_idx_o = idx. sample_last_o = sample_valid_o && (idx == POINTS-1).
  - All outputs are combinational from registers.
  - Latency: a frame accepted at edge N, with count previously 0, presents sample 0 in the cycle following edge N.
- Sample transfer:
  - A transfer occurs on sample_valid_o && sample_ready_i: idx increments.
  - On a transfer with idx==POINTS-1: idx wraps to 0, rd_ptr toggles, and the frame is released.
- Count update:
  - Accept only: count+1.
  - Release only: count-1.
  - Accept and release in the same cycle: count unchanged, both pointers toggle.
  - Full (count==2): frame_ready_o=0, even if a release happens that cycle. The frame is accepted on the following cycle.
- Backpressure:
  - sample_ready_i low holds sample_o, sample_idx_o and sample_last_o stable.
  - The held buffer is never overwritten while draining.
- Inputs ignored:
  - frame_i and frame_valid_i are ignored when frame_ready_o=0.
  - frame_valid_i may deassert at any time without penalty.
- Back-to-back streaming:
  - With two frames held and sample_ready_i constantly high, output is gap-free: sample_last_o of frame A is followed directly by idx 0 of frame B.
- bitrev(x): reverse the log2(POINTS) index bits. For POINTS=8, k=0..7 maps to frame index 0,4,2,6,1,5,3,7.
- No arithmetic on samples; sign bits are never interpreted.

Test Plan:
- Reset then single frame:
  - Stimulus: frame_i[j]=j+1 (imag field), sample_ready_i=1.
  - Response: sample_o imag sequence 1,5,3,7,2,6,4,8; sample_idx_o 0..7; sample_last_o only on the 8th; sample_valid_o low afterwards.
- BIT_REVERSE=0:
  - Stimulus: same frame.
  - Response: sequence 1..8 in order.
- Backpressure:
  - Stimulus: sample_ready_i toggles 1,0,0,1 repeatedly.
  - Response: each sample held stable while ready=0; no sample lost or duplicated; all 8 delivered.
- Ping-pong full:
  - Stimulus: frames A then B on consecutive cycles, sample_ready_i=0, third frame C presented.
  - Response: frame_ready_o=0 after B; C accepted only the cycle after A's last sample transfers.
  - Then: output is A then B gap-free, then C.
- Simultaneous accept and release:
  - Stimulus: count=1, new frame valid on the same edge as the last-sample transfer.
  - Response: count stays 1; next cycle presents idx 0 of the new frame.
- Async reset mid-frame:
  - Stimulus: assert rst_i low between clock edges after 3 samples transferred.
  - Response: sample_valid_o=0 and frame_ready_o=1 immediately, without waiting for a clock edge.
  - After release: no output until a new frame is accepted; the new frame starts at idx 0.

Source files
------------

// File: rtl/fft_frame_unloader.sv
// FFT output stage: ping-pong holds two parallel 8-point frames and streams
// them one complex sample per cycle, optionally undoing bit-reversed order.
module fft_frame_unloader #(
    parameter int DATA_W      = 50,
    parameter int POINTS      = 8,
    parameter int BIT_REVERSE = 1
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [DATA_W-1:0]          frame_i [POINTS-1:0],
    input  logic                       frame_valid_i,
    output logic                       frame_ready_o,
    output logic [DATA_W-1:0]          sample_o,
    output logic [$clog2(POINTS)-1:0]  sample_idx_o,
    output logic                       sample_valid_o,
    output logic                       sample_last_o,
    input  logic                       sample_ready_i
);

    localparam int IW = $clog2(POINTS);
    localparam logic [IW-1:0] LAST = IW'(POINTS - 1);

    logic [DATA_W-1:0] frame_buf [2][POINTS];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [IW-1:0]     idx;
    logic [IW-1:0]     rd_addr;
    logic              accept;
    logic              xfer;
    logic              rel;

    function automatic logic [IW-1:0] bitrev(input logic [IW-1:0] x);
        logic [IW-1:0] r;
        for (int b = 0; b < IW; b++) begin
            r[b] = x[IW-1-b];
        end
        return r;
    endfunction

    assign rd_addr = (BIT_REVERSE != 0) ? bitrev(idx) : idx;

    assign frame_ready_o  = (count != 2'd2);
    assign sample_valid_o = (count != 2'd0);
    assign sample_o       = sample_valid_o ? frame_buf[rd_ptr][rd_addr] : '0;
    assign sample_idx_o   = idx;
    assign sample_last_o  = sample_valid_o && (idx == LAST);

    assign accept = frame_valid_i && frame_ready_o;
    assign xfer   = sample_valid_o && sample_ready_i;
    assign rel    = xfer && (idx == LAST);

    // Ready depends only on count, so a full unloader never writes the
    // buffer being drained even when that buffer releases this cycle.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            idx    <= '0;
            for (int b = 0; b < 2; b++) begin
                for (int p = 0; p < POINTS; p++) begin
                    frame_buf[b][p] <= '0;
                end
            end
        end else begin
            if (accept) begin
                for (int p = 0; p < POINTS; p++) begin
                    frame_buf[wr_ptr][p] <= frame_i[p];
                end
                wr_ptr <= ~wr_ptr;
            end
            if (xfer) begin
                idx <= idx + 1'b1;
            end
            if (rel) begin
                rd_ptr <= ~rd_ptr;
            end
            if (accept && !rel) begin
                count <= count + 2'd1;
            end else if (!accept && rel) begin
                count <= count - 2'd1;
            end
        end
    end

endmodule
